// File: rtl/sram_cache_controller_pkg.sv
// Shared definitions for the SRAM-side cache: FSM encoding, address split, line width.
package sram_cache_controller_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_e;

    localparam int DEF_BASE_ADDR = 1024;
    localparam int DEF_SETS      = 64;
    localparam int DEF_TAG_W     = 10;

    // Bit positions within (address - BASE_ADDR)
    localparam int WORD_BIT = 2;
    localparam int IDX_LSB  = 3;
    localparam int IDX_W    = 6;
    localparam int TAG_LSB  = IDX_LSB + IDX_W;

    localparam int LINE_W = 64;

    // Pick the even (sel=0) or odd (sel=1) 32-bit word of a line
    function automatic logic [31:0] word_of(input logic [LINE_W-1:0] line, input logic sel);
        return sel ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/sram_cache_controller_way.sv
// One cache way: valid/tag/data per set, synchronous write, combinational read.
module cache_way_array
    import sram_cache_controller_pkg::*;
#(
    parameter int SETS  = DEF_SETS,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(SETS)-1:0] idx_i,
    input  logic                    fill_en_i,
    input  logic [TAG_W-1:0]        fill_tag_i,
    input  logic [LINE_W-1:0]       fill_line_i,
    input  logic                    word_en_i,
    input  logic                    word_sel_i,
    input  logic [31:0]             word_i,
    output logic                    valid_o,
    output logic [TAG_W-1:0]        tag_o,
    output logic [LINE_W-1:0]       line_o
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] line_q [SETS];

    // Valid bits are the only state that needs clearing; stale tags/data are masked by valid
    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= '0;
        else if (fill_en_i)
            valid_q[idx_i] <= 1'b1;
    end

    // Tag/data: whole-line fill on a read miss, single-word update on a write hit
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            line_q[idx_i] <= fill_line_i;
        end else if (word_en_i) begin
            if (word_sel_i)
                line_q[idx_i][63:32] <= word_i;
            else
                line_q[idx_i][31:0]  <= word_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = line_q[idx_i];

endmodule

// File: rtl/sram_cache_controller.sv
// 2-way set-associative write-through, no-write-allocate cache in front of the SRAM controller.
module sram_cache_controller
    import sram_cache_controller_pkg::*;
#(
    parameter int BASE_ADDR = DEF_BASE_ADDR,
    parameter int SETS      = DEF_SETS,
    parameter int TAG_W     = DEF_TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_r_en,
    output logic        sram_w_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int IW = $clog2(SETS);

    state_e            state_q, state_d;
    logic [SETS-1:0]   lru_q;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       a;
    logic [IW-1:0]     idx;
    logic [TAG_W-1:0]  tag;
    logic              wsel;
    logic              unused_bits;

    logic [1:0]        way_valid, hit, fill_en, word_en;
    logic [TAG_W-1:0]  way_tag  [2];
    logic [LINE_W-1:0] way_line [2];
    logic              hit_way, victim, lru_we, lru_new;

    assign a           = address - 32'(BASE_ADDR);
    assign wsel        = a[WORD_BIT];
    assign idx         = a[IDX_LSB +: IW];
    assign tag         = a[TAG_LSB +: TAG_W];
    assign unused_bits = ^{a[31:TAG_LSB+TAG_W], a[1:0]};

    assign sram_address = address;
    assign sram_wdata   = wdata;

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way_array #(.SETS(SETS), .TAG_W(TAG_W)) u_way (
            .clk        (clk),
            .rst        (rst),
            .idx_i      (idx),
            .fill_en_i  (fill_en[w] & ~rst),
            .fill_tag_i (tag),
            .fill_line_i(sram_rdata),
            .word_en_i  (word_en[w] & ~rst),
            .word_sel_i (wsel),
            .word_i     (wdata),
            .valid_o    (way_valid[w]),
            .tag_o      (way_tag[w]),
            .line_o     (way_line[w])
        );
        assign hit[w] = way_valid[w] && (way_tag[w] == tag);
    end

    assign hit_way = ~hit[0];
    assign victim  = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[idx]);

    // State, LRU and held load data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lru_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (lru_we)
                lru_q[idx] <= lru_new;
        end
    end

    // Next state, handshake outputs and cache update strobes
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        ready     = 1'b1;
        sram_r_en = 1'b0;
        sram_w_en = 1'b0;
        fill_en   = '0;
        word_en   = '0;
        lru_we    = 1'b0;
        lru_new   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_w_en) begin
                    ready   = 1'b0;
                    state_d = WRITE;
                end else if (mem_r_en) begin
                    if (|hit) begin
                        rdata_d = word_of(way_line[hit_way], wsel);
                        lru_we  = 1'b1;
                        lru_new = ~hit_way;
                    end else begin
                        ready   = 1'b0;
                        state_d = READ_MISS;
                    end
                end
            end
            READ_MISS: begin
                sram_r_en = 1'b1;
                ready     = sram_ready;
                if (sram_ready) begin
                    rdata_d         = word_of(sram_rdata, wsel);
                    fill_en[victim] = 1'b1;
                    lru_we          = 1'b1;
                    lru_new         = ~victim;
                    state_d         = IDLE;
                end
            end
            WRITE: begin
                sram_w_en = 1'b1;
                ready     = sram_ready;
                if (sram_ready) begin
                    if (|hit) begin
                        word_en[hit_way] = 1'b1;
                        lru_we           = 1'b1;
                        lru_new          = ~hit_way;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdata = rdata_d;

endmodule

// File: tb/tb_sram_cache_controller.sv
// Directed table-driven bench for sram_cache_controller with a mid-miss reset sequence.
module tb_sram_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, wdata, rdata, sram_address, sram_wdata;
    logic        mem_r_en, mem_w_en, ready, sram_r_en, sram_w_en, sram_ready;
    logic [63:0] sram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    localparam int K_HIT = 0, K_RD = 1, K_WR = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rd;
        logic        wr;
        logic [63:0] line;
        int          dly;
        int          kind;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[19];

    sram_cache_controller dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .rdata(rdata), .ready(ready),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wd, input logic rd,
                                input logic wr, input logic [63:0] line, input int dly,
                                input int kind, input logic [31:0] exp);
        vec_t v;
        v.addr = addr; v.wd = wd; v.rd = rd; v.wr = wr;
        v.line = line; v.dly = dly; v.kind = kind; v.exp = exp;
        return v;
    endfunction

    // Apply one request; the SRAM side is played by the bench with a fixed latency
    task automatic run(input vec_t v, input int n);
        string tg;
        tg = $sformatf("v%0d", n);
        @(negedge clk);
        address = v.addr; wdata = v.wd; mem_r_en = v.rd; mem_w_en = v.wr; sram_ready = 1'b0;
        #1;
        chk({tg, "_sram_addr"}, sram_address, v.addr);
        if (v.kind == K_HIT) begin
            chk({tg, "_hit_ready"}, ready, 1);
            chk({tg, "_hit_rdata"}, rdata, v.exp);
            chk({tg, "_hit_no_r_en"}, sram_r_en, 0);
        end else begin
            chk({tg, "_stall"}, ready, 0);
            for (int i = 0; i < v.dly; i++) begin
                @(negedge clk); #1;
                chk({tg, "_busy_ready"}, ready, 0);
                chk({tg, "_busy_r_en"}, sram_r_en, (v.kind == K_RD));
                chk({tg, "_busy_w_en"}, sram_w_en, (v.kind == K_WR));
            end
            @(negedge clk);
            sram_ready = 1'b1; sram_rdata = v.line;
            #1;
            chk({tg, "_done_ready"}, ready, 1);
            if (v.kind == K_RD) chk({tg, "_done_rdata"}, rdata, v.exp);
            else                chk({tg, "_sram_wdata"}, sram_wdata, v.wd);
        end
        @(negedge clk);
        mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = 1'b0;
        #1;
        chk({tg, "_idle_r_en"}, sram_r_en, 0);
        chk({tg, "_idle_w_en"}, sram_w_en, 0);
        chk({tg, "_idle_ready"}, ready, 1);
        if (v.kind != K_WR) chk({tg, "_rdata_hold"}, rdata, v.exp);
    endtask

    initial begin
        tbl[0]  = mk(32'h400,  0, 1, 0, 64'h22222222_11111111, 2, K_RD,  32'h11111111);
        tbl[1]  = mk(32'h404,  0, 1, 0, 0,                     0, K_HIT, 32'h22222222);
        tbl[2]  = mk(32'h800,  0, 1, 0, 64'h44444444_33333333, 1, K_RD,  32'h33333333);
        tbl[3]  = mk(32'h400,  0, 1, 0, 0,                     0, K_HIT, 32'h11111111);
        tbl[4]  = mk(32'hC00,  0, 1, 0, 64'h66666666_55555555, 3, K_RD,  32'h55555555);
        tbl[5]  = mk(32'h400,  0, 1, 0, 0,                     0, K_HIT, 32'h11111111);
        tbl[6]  = mk(32'h800,  0, 1, 0, 64'h88888888_77777777, 1, K_RD,  32'h77777777);
        tbl[7]  = mk(32'h404,  32'hDEADBEEF, 0, 1, 0,          2, K_WR,  0);
        tbl[8]  = mk(32'h404,  0, 1, 0, 0,                     0, K_HIT, 32'hDEADBEEF);
        tbl[9]  = mk(32'h400,  0, 1, 0, 0,                     0, K_HIT, 32'h11111111);
        tbl[10] = mk(32'h1000, 32'h12345678, 0, 1, 0,          1, K_WR,  0);
        tbl[11] = mk(32'h1000, 0, 1, 0, 64'hAAAAAAAA_99999999, 2, K_RD,  32'h99999999);
        tbl[12] = mk(32'h404,  0, 1, 0, 0,                     0, K_HIT, 32'hDEADBEEF);
        tbl[13] = mk(32'h40C,  0, 1, 0, 64'hFEEDFACE_01234567, 1, K_RD,  32'hFEEDFACE);
        tbl[14] = mk(32'h408,  0, 1, 0, 0,                     0, K_HIT, 32'h01234567);
        tbl[15] = mk(32'h408,  32'h0BADF00D, 1, 1, 0,          1, K_WR,  0);
        tbl[16] = mk(32'h408,  0, 1, 0, 0,                     0, K_HIT, 32'h0BADF00D);
        tbl[17] = mk(32'h1004, 0, 1, 0, 0,                     0, K_HIT, 32'hAAAAAAAA);
        tbl[18] = mk(32'h800,  0, 1, 0, 64'h12121212_34343434, 1, K_RD,  32'h34343434);

        rst = 1'b1; address = 0; wdata = 0; mem_r_en = 0; mem_w_en = 0;
        sram_ready = 0; sram_rdata = 0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_r_en", sram_r_en, 0);
        chk("rst_w_en", sram_w_en, 0);
        chk("rst_rdata", rdata, 0);

        foreach (tbl[i]) run(tbl[i], i);

        // Reset while a read miss is waiting on the SRAM controller
        @(negedge clk);
        address = 32'h600; mem_r_en = 1'b1;
        #1; chk("mr_stall", ready, 0);
        @(negedge clk); #1;
        chk("mr_r_en", sram_r_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_r_en = 1'b0;
        #1;
        chk("mr_after_r_en", sram_r_en, 0);
        chk("mr_after_ready", ready, 1);
        chk("mr_after_rdata", rdata, 0);
        run(mk(32'h1004, 0, 1, 0, 64'hBBBBBBBB_CCCCCCCC, 1, K_RD,  32'hBBBBBBBB), 100);
        run(mk(32'h1000, 0, 1, 0, 0,                     0, K_HIT, 32'hCCCCCCCC), 101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
